// File: rtl/hamming_15_11_codec.sv
// Registered Hamming(15,11) single-error-correcting codec.
// Independent encoder and decoder halves, each with one cycle of latency.
module hamming_15_11_codec (
    input  logic         clk,
    input  logic         reset,
    input  logic         enc_valid_in,
    input  logic [11:1]  enc_data_in,
    output logic         enc_valid_out,
    output logic [15:1]  enc_code_out,
    input  logic         dec_valid_in,
    input  logic [15:1]  dec_code_in,
    output logic         dec_valid_out,
    output logic [11:1]  dec_data_out,
    output logic [3:0]   dec_syndrome,
    output logic         dec_err
);

    function automatic logic [15:1] encode(input logic [11:1] d);
        logic [15:1] c;
        c       = '0;
        c[3]    = d[1];
        c[5]    = d[2];
        c[6]    = d[3];
        c[7]    = d[4];
        c[15:9] = d[11:5];
        c[1]    = c[3] ^ c[5] ^ c[7]  ^ c[9]  ^ c[11] ^ c[13] ^ c[15];
        c[2]    = c[3] ^ c[6] ^ c[7]  ^ c[10] ^ c[11] ^ c[14] ^ c[15];
        c[4]    = c[5] ^ c[6] ^ c[7]  ^ c[12] ^ c[13] ^ c[14] ^ c[15];
        c[8]    = c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
        return c;
    endfunction

    logic [3:0]  syndrome;
    logic [15:1] corrected;
    logic [11:1] extracted;

    // Syndrome is the XOR of the positions of all set bits; it names the bad position directly.
    always_comb begin
        syndrome = '0;
        for (int k = 1; k <= 15; k++) begin
            if (dec_code_in[k]) begin
                syndrome = syndrome ^ 4'(k);
            end
        end
        corrected = dec_code_in;
        if (syndrome != 4'd0) begin
            corrected[syndrome] = ~dec_code_in[syndrome];
        end
        extracted = {corrected[15:9], corrected[7], corrected[6], corrected[5], corrected[3]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enc_valid_out <= 1'b0;
            enc_code_out  <= '0;
            dec_valid_out <= 1'b0;
            dec_data_out  <= '0;
            dec_syndrome  <= '0;
            dec_err       <= 1'b0;
        end else begin
            enc_valid_out <= enc_valid_in;
            dec_valid_out <= dec_valid_in;
            if (enc_valid_in) begin
                enc_code_out <= encode(enc_data_in);
            end
            if (dec_valid_in) begin
                dec_data_out <= extracted;
                dec_syndrome <= syndrome;
                dec_err      <= (syndrome != 4'd0);
            end
        end
    end

endmodule

// File: tb/tb_hamming_15_11_codec.sv
// Scoreboard bench for hamming_15_11_codec: stimulus pushes expectations,
// a negedge monitor pops and compares whenever a valid output appears.
module tb_hamming_15_11_codec;

    logic         clk;
    logic         reset;
    logic         enc_valid_in;
    logic [11:1]  enc_data_in;
    logic         enc_valid_out;
    logic [15:1]  enc_code_out;
    logic         dec_valid_in;
    logic [15:1]  dec_code_in;
    logic         dec_valid_out;
    logic [11:1]  dec_data_out;
    logic [3:0]   dec_syndrome;
    logic         dec_err;

    typedef struct {
        logic [11:1] data;
        logic [3:0]  syn;
        logic        err;
    } dec_exp_t;

    logic [15:1] enc_queue[$];
    dec_exp_t    dec_queue[$];

    int checks   = 0;
    int failures = 0;

    logic [15:1] enc_last;
    dec_exp_t    dec_last;

    hamming_15_11_codec dut (
        .clk           (clk),
        .reset         (reset),
        .enc_valid_in  (enc_valid_in),
        .enc_data_in   (enc_data_in),
        .enc_valid_out (enc_valid_out),
        .enc_code_out  (enc_code_out),
        .dec_valid_in  (dec_valid_in),
        .dec_code_in   (dec_code_in),
        .dec_valid_out (dec_valid_out),
        .dec_data_out  (dec_data_out),
        .dec_syndrome  (dec_syndrome),
        .dec_err       (dec_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Independent reference: place data, then build each parity bit from position indices.
    function automatic logic [15:1] model_encode(input logic [11:1] d);
        int          dpos[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        logic [15:1] c;
        logic        p;
        c = '0;
        for (int i = 1; i <= 11; i++) c[dpos[i-1]] = d[i];
        for (int j = 0; j < 4; j++) begin
            p = 1'b0;
            for (int k = 3; k <= 15; k++) begin
                if ((k & (k - 1)) != 0 && ((k >> j) & 1) == 1) p = p ^ c[k];
            end
            c[1 << j] = p;
        end
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ev, input logic [11:1] ed, input logic [15:1] ecode,
                                 input logic dv, input logic [15:1] dc, input logic [11:1] dd,
                                 input logic [3:0] ds, input logic de);
        dec_exp_t e;
        enc_valid_in = ev;
        enc_data_in  = ed;
        dec_valid_in = dv;
        dec_code_in  = dc;
        if (ev) enc_queue.push_back(ecode);
        if (dv) begin
            e.data = dd;
            e.syn  = ds;
            e.err  = de;
            dec_queue.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 4'd0, 1'b0);
    endtask

    // Monitor: pop on valid output, otherwise outputs must hold the last delivered value.
    always @(negedge clk) begin
        if (reset) begin
            enc_last      = '0;
            dec_last.data = '0;
            dec_last.syn  = '0;
            dec_last.err  = 1'b0;
        end else begin
            if (enc_valid_out === 1'b1) begin
                if (enc_queue.size() == 0) begin
                    checkOutput("enc_unexpected_valid", 16'd1, 16'd0);
                end else begin
                    enc_last = enc_queue.pop_front();
                    checkOutput("enc_code", {1'b0, enc_code_out}, {1'b0, enc_last});
                end
            end else begin
                checkOutput("enc_hold", {1'b0, enc_code_out}, {1'b0, enc_last});
            end
            if (dec_valid_out === 1'b1) begin
                if (dec_queue.size() == 0) begin
                    checkOutput("dec_unexpected_valid", 16'd1, 16'd0);
                end else begin
                    dec_last = dec_queue.pop_front();
                    checkOutput("dec_data", {5'd0, dec_data_out}, {5'd0, dec_last.data});
                    checkOutput("dec_syndrome", {12'd0, dec_syndrome}, {12'd0, dec_last.syn});
                    checkOutput("dec_err", {15'd0, dec_err}, {15'd0, dec_last.err});
                end
            end else begin
                checkOutput("dec_data_hold", {5'd0, dec_data_out}, {5'd0, dec_last.data});
                checkOutput("dec_syndrome_hold", {12'd0, dec_syndrome}, {12'd0, dec_last.syn});
                checkOutput("dec_err_hold", {15'd0, dec_err}, {15'd0, dec_last.err});
            end
        end
    end

    initial begin
        logic [11:1] d;
        logic [15:1] code;
        logic [15:1] mask;
        int          waited;

        // Reset held with both valids high must still clear everything.
        reset        = 1'b1;
        enc_valid_in = 1'b1;
        enc_data_in  = 11'h7FF;
        dec_valid_in = 1'b1;
        dec_code_in  = 15'h7FFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_enc_valid", {15'd0, enc_valid_out}, 16'd0);
        checkOutput("reset_enc_code", {1'b0, enc_code_out}, 16'd0);
        checkOutput("reset_dec_valid", {15'd0, dec_valid_out}, 16'd0);
        checkOutput("reset_dec_data", {5'd0, dec_data_out}, 16'd0);
        checkOutput("reset_dec_syndrome", {12'd0, dec_syndrome}, 16'd0);
        checkOutput("reset_dec_err", {15'd0, dec_err}, 16'd0);
        enc_valid_in = 1'b0;
        dec_valid_in = 1'b0;
        reset        = 1'b0;
        idleCycle();

        // Hand-computed directed vectors, back to back.
        applyStimulus(1'b1, 11'h000, 15'h0000, 1'b1, 15'h0000, 11'h000, 4'd0, 1'b0);
        applyStimulus(1'b1, 11'h7FF, 15'h7FFF, 1'b1, 15'h7FFF, 11'h7FF, 4'd0, 1'b0);
        applyStimulus(1'b1, 11'h001, 15'h0007, 1'b1, 15'h0017, 11'h001, 4'd5, 1'b1);
        applyStimulus(1'b1, 11'h400, 15'h408B, 1'b1, 15'h400B, 11'h400, 4'd8, 1'b1);

        // Same vectors with gaps; outputs must hold while idle.
        applyStimulus(1'b1, 11'h001, 15'h0007, 1'b0, '0, '0, 4'd0, 1'b0);
        idleCycle();
        idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b1, 15'h400B, 11'h400, 4'd8, 1'b1);
        idleCycle();
        applyStimulus(1'b1, 11'h400, 15'h408B, 1'b1, 15'h0017, 11'h001, 4'd5, 1'b1);
        idleCycle();
        applyStimulus(1'b1, 11'h7FF, 15'h7FFF, 1'b0, '0, '0, 4'd0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 15'h0000, 11'h000, 4'd0, 1'b0);
        idleCycle();

        // Sweep: every single-bit flip position plus no flip, for 50 words.
        for (int w = 0; w < 50; w++) begin
            d    = 11'($urandom_range(0, 2047));
            code = model_encode(d);
            for (int f = 0; f <= 15; f++) begin
                mask = '0;
                if (f != 0) mask[f] = 1'b1;
                applyStimulus((f % 4) != 3, d, code,
                              1'b1, code ^ mask, d, 4'(f), f != 0);
            end
            if (w % 10 == 9) idleCycle();
        end

        waited = 0;
        while ((enc_queue.size() != 0 || dec_queue.size() != 0) && waited < 20) begin
            idleCycle();
            @(negedge clk);
            #1;
            waited++;
        end
        idleCycle();
        checkOutput("enc_queue_drained", 16'(enc_queue.size()), 16'd0);
        checkOutput("dec_queue_drained", 16'(dec_queue.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hamming_15_11_codec.md
Name: hamming_15_11_codec

Overview:
Registered Hamming(15,11) single-error-correcting codec. The encoder half turns an 11-bit data word into a 15-bit codeword with four even-parity bits. The decoder half takes a received 15-bit word, which may have one bit flipped, and returns the corrected 11-bit data word plus status. The two halves are independent and sit between a data source and a noisy channel/storage model.

Parameters:
None. Widths are fixed at 11 data bits and 15 code bits.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
enc_valid_in  in  1  enc_data_in is valid this cycle
enc_data_in  in  11  data word, bits numbered [11:1]
enc_valid_out  out  1  enc_code_out is valid
enc_code_out  out  15  codeword, bits numbered [15:1]; bit k is code position k
dec_valid_in  in  1  dec_code_in is valid this cycle
dec_code_in  in  15  received word, bits numbered [15:1]
dec_valid_out  out  1  decoder outputs are valid
dec_data_out  out  11  corrected data word, bits numbered [11:1]
dec_syndrome  out  4  syndrome; 0 means no error, k means position k was in error
dec_err  out  1  1 when the syndrome is nonzero and a bit was corrected

Behaviour:
- Reset is synchronous: at a rising clk edge with reset=1, every output goes to 0, including both valid flags. Reset overrides any valid input in the same cycle.
- Code layout: parity bits occupy positions 1, 2, 4 and 8. Data occupies the remaining positions in ascending order:
  - d[1]→3, d[2]→5, d[3]→6, d[4]→7
  - d[5]→9, d[6]→10, d[7]→11, d[8]→12, d[9]→13, d[10]→14, d[11]→15
- Parity is even. The parity bit at position 2^j is the XOR of all data positions p (3..15, excluding powers of two) whose index has bit j set:
  - P1 = c3^c5^c7^c9^c11^c13^c15
  - P2 = c3^c6^c7^c10^c11^c14^c15
  - P4 = c5^c6^c7^c12^c13^c14^c15
  - P8 = c9^c10^c11^c12^c13^c14^c15
- Encoder:
  - Latency is 1 cycle. enc_valid_out is enc_valid_in registered.
  - enc_code_out is updated only on a cycle where enc_valid_in=1; otherwise it holds its value.
- Decoder:
  - Latency is 1 cycle. dec_valid_out is dec_valid_in registered.
  - Syndrome s = XOR of the indices k (1..15) of every received bit equal to 1; equivalently, recomputed parity XOR received parity.
  - If s≠0, invert received position s before extracting data. All four bits of s address valid positions 1..15, so there is no out-of-range case.
  - Data is extracted with the inverse of the layout mapping.
  - dec_err = (s≠0). dec_syndrome = s.
  - All decoder outputs update only on a cycle where dec_valid_in=1; otherwise they hold.
- An error in a parity position (1, 2, 4, 8) yields the matching syndrome, and dec_data_out equals the original data.
- Double-bit errors are outside scope. The codec still applies the single-bit correction rule, giving miscorrected data with dec_err=1; no detection is required.
- Encoder and decoder may both be active in the same cycle with no interaction.
- Back-to-back valid inputs are accepted every cycle, giving full throughput with no stalls.
- No handshake backpressure.

Test Plan:
- Reset is held while both valid inputs are 1 → all outputs are 0 the next cycle. After reset is released, the first valid input produces output 1 cycle later.
- enc_data_in=11'h000 → enc_code_out=15'h0000. enc_data_in=11'h7FF → 15'h7FFF. Each decoded with no flip → data is returned unchanged, dec_syndrome=0, dec_err=0.
- enc_data_in=11'h001 → enc_code_out=15'h0007. Decoding 15'h0017 (position 5 flipped) → dec_data_out=11'h001, dec_syndrome=5, dec_err=1.
- enc_data_in=11'h400 → enc_code_out=15'h408B. Decoding 15'h400B (parity position 8 flipped) → dec_data_out=11'h400, dec_syndrome=8, dec_err=1.
- Random sweep of ≥50 words, with loopback of encoder output through a single-bit flip at every position 1..15 plus the no-flip case:
  - dec_data_out always equals the original data.
  - dec_syndrome equals the flipped position, or 0 for no flip.
- Valid inputs pulsed every cycle, then with gaps → outputs track at 1-cycle latency and hold during gaps.
